eflags_reg_unit: RTL and testbench
==================================

Name: eflags_reg_unit

Overview:
- Registered successor to the combinational flag helpers.
- Computes OF/SF/ZF/AF/PF/CF from an ALU result at a selectable operand size (8/16/32, up to WIDTH).
- Merges the computed flags into the architectural EFLAGS under a per-flag update mask. Also supports DF writes (STD/CLD) and full loads (POPF).
- Sits at the end of the execute stage. Provides a registered EFLAGS for consumers and a same-cycle forwarding value for back-to-back dependent ops.

Parameters:
- WIDTH, 32, max operand width. Legal values: 8, 16, 32.
- RESET_FLAGS, 32'h0000_0000, EFLAGS value loaded on reset. Non-implemented bits are ignored.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- v_in  input  1  an op is presented this cycle.
- stall  input  1  downstream stall; hold all state.
- flush  input  1  squash the op presented this cycle.
- size  input  2  operand size: 00=8, 01=16, 10=32, 11=reserved (treated as WIDTH).
- a  input  WIDTH  ALU operand A.
- b  input  WIDTH  ALU operand B, pre-inversion.
- result  input  WIDTH  ALU result.
- carry_out  input  1  adder carry out of the size-msb.
- is_sub  input  1  op is SUB/CMP/SBB/NEG-class.
- upd_mask  input  7  flag write enables, bit order {OF,DF,SF,ZF,AF,PF,CF} = [6:0].
- df_val  input  1  value written to DF when upd_mask[5]=1.
- load_en  input  1  full EFLAGS load (POPF).
- load_val  input  32  EFLAGS value for load_en.
- flags  output  32  architectural EFLAGS (registered).
- flags_fwd  output  32  combinational next-EFLAGS value for forwarding.
- v_out  output  1  registered: an op was committed last edge.

Behaviour:
- Flag bit positions: OF=11, DF=10, SF=7, ZF=6, AF=4, PF=2, CF=0. All other bits of flags and flags_fwd are always 0, including after load_en.
- msb = 7, 15 or 31 per size, clamped to WIDTH-1. Bits of a, b and result above msb are ignored.
- Computed flags:
  - SF = result[msb].
  - ZF = 1 iff result[msb:0] == 0.
  - PF = even parity of result[7:0], regardless of size.
  - AF = a[4] ^ b[4] ^ result[4].
  - b_eff = b[msb] ^ is_sub; OF = (a[msb] ~^ b_eff) & (a[msb] ^ result[msb]).
  - CF = carry_out ^ is_sub (borrow for subtract).
- Merge: each flag whose mask bit is 1 takes its new value (DF takes df_val); each flag whose mask bit is 0 keeps the old value. load_en overrides the mask and takes load_val masked to the implemented bits.
- Accept condition: acc = v_in & ~stall & ~flush & ~reset.
- flags_fwd equals the merged value when acc=1, else equals flags. It is purely combinational (zero latency).
- Rising edge behaviour:
  - reset=1: flags <= RESET_FLAGS & implemented-mask, v_out <= 0. This overrides everything, including mid-stall.
  - acc=1: flags <= merged value, v_out <= 1.
  - stall=1: flags and v_out hold.
  - Otherwise (idle or flush): flags hold, v_out <= 0.
- Simultaneous stall and flush: stall wins, so flags and v_out hold. flush is only effective when stall=0.
- Latency: 1 cycle from accepted op to flags/v_out. Back-to-back accepted ops update every cycle with no bubble.
- upd_mask=0 with v_in=1: v_out still pulses; flags are unchanged.
- WIDTH=8: size is ignored and msb is always 7. WIDTH=16: size 10/11 are treated as 16.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> flags=0, v_out=0, flags_fwd=0 during and after.
- ADD8 overflow: size=00, a=0x7F, b=0x01, result=0x80, carry_out=0, is_sub=0, mask=7'b1011111 -> next cycle flags=0x0890 (OF,SF,AF) with PF=0, CF=0, ZF=0, DF unchanged.
- CMP32 equal: size=10, a=b=0x12345678, result=0, carry_out=1, is_sub=1, mask all except DF -> flags=0x0044 (ZF,PF), CF=0, OF=0.
- Masked/DF: start with flags=0x0001; apply STD op (mask=0100000, df_val=1) -> flags=0x0401. Then an INC-class op with CF masked off and result=0 -> CF stays 1.
- POPF and stall: load_en with load_val=0xFFFF_FFFF -> flags=0x0CD5. Then stall=1 with flush=1 and v_in=1 for 3 cycles -> flags=0x0CD5 held, v_out held. Then flush alone -> v_out=0, no update.
- Back-to-back forwarding: two consecutive ops with ZF results 1 then 0 -> flags_fwd shows each merged value in its own cycle, flags lags by exactly 1 cycle, and v_out=1 for 2 cycles.

Source files
------------

// File: rtl/eflags_reg_unit.sv
// eflags_reg_unit: computes ALU status flags, merges them into a registered EFLAGS, and forwards the next value.
module eflags_reg_unit #(
  parameter int WIDTH = 32,
  parameter logic [31:0] RESET_FLAGS = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       size,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_out,
  input  logic             is_sub,
  input  logic [6:0]       upd_mask,
  input  logic             df_val,
  input  logic             load_en,
  input  logic [31:0]      load_val,
  output logic [31:0]      flags,
  output logic [31:0]      flags_fwd,
  output logic             v_out
);
  localparam logic [31:0] IMPL = 32'h0000_0CD5;
  localparam int H16 = (WIDTH < 16) ? WIDTH - 1 : 15;
  logic [1:0] sz;
  logic [WIDTH-1:0] zmask;
  logic a_s, b_s, r_s, of_n, sf_n, zf_n, af_n, pf_n, cf_n, acc;
  logic [31:0] nf, mexp, merged;
  always_comb begin
    sz = (WIDTH == 8) ? 2'd0 : (size == 2'b11) ? 2'd2 : (WIDTH == 16 && size == 2'b10) ? 2'd1 : size;
    zmask = (sz == 2'd0) ? WIDTH'(32'h0000_00FF) : (sz == 2'd1) ? WIDTH'(32'h0000_FFFF) : {WIDTH{1'b1}};
    a_s = (sz == 2'd0) ? a[7] : (sz == 2'd1) ? a[H16] : a[WIDTH-1];
    b_s = (sz == 2'd0) ? b[7] : (sz == 2'd1) ? b[H16] : b[WIDTH-1];
    r_s = (sz == 2'd0) ? result[7] : (sz == 2'd1) ? result[H16] : result[WIDTH-1];
    sf_n = r_s;
    zf_n = ((result & zmask) == '0);
    pf_n = ~^result[7:0];
    af_n = a[4] ^ b[4] ^ result[4];
    of_n = (a_s ~^ (b_s ^ is_sub)) & (a_s ^ r_s);
    cf_n = carry_out ^ is_sub;
    nf = {20'b0, of_n, df_val, 2'b0, sf_n, zf_n, 1'b0, af_n, 1'b0, pf_n, 1'b0, cf_n};
    mexp = {20'b0, upd_mask[6], upd_mask[5], 2'b0, upd_mask[4], upd_mask[3], 1'b0,
            upd_mask[2], 1'b0, upd_mask[1], 1'b0, upd_mask[0]};
    merged = load_en ? (load_val & IMPL) : (((flags & ~mexp) | (nf & mexp)) & IMPL);
    acc = v_in & ~stall & ~flush & ~reset;
    flags_fwd = acc ? merged : flags;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= RESET_FLAGS & IMPL;
      v_out <= 1'b0;
    end else if (acc) begin
      flags <= merged;
      v_out <= 1'b1;
    end else if (!stall) v_out <= 1'b0;
  end
endmodule

// File: tb/tb_eflags_reg_unit.sv
// tb_eflags_reg_unit: directed vectors; committed flags checked from a scoreboard queue when v_out shows a commit.
module tb_eflags_reg_unit;
  logic clk = 0, reset, v_in, stall, flush, carry_out, is_sub, df_val, load_en;
  logic [1:0] size;
  logic [31:0] a, b, result, load_val, flags, flags_fwd;
  logic [6:0] upd_mask;
  logic v_out;
  int total = 0, bad = 0;
  logic [31:0] sb_q[$];

  eflags_reg_unit dut (.clk(clk), .reset(reset), .v_in(v_in), .stall(stall), .flush(flush),
    .size(size), .a(a), .b(b), .result(result), .carry_out(carry_out), .is_sub(is_sub),
    .upd_mask(upd_mask), .df_val(df_val), .load_en(load_en), .load_val(load_val),
    .flags(flags), .flags_fwd(flags_fwd), .v_out(v_out));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // A commit is new only if the edge that produced it was not a stall or reset edge.
  initial forever begin
    logic st, rs;
    @(posedge clk);
    st = stall;
    rs = reset;
    #1;
    if (!st && !rs && v_out === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_commit", 32'd1, 32'd0);
      else chk("committed_flags", flags, sb_q.pop_front());
    end
  end

  task automatic idle();
    v_in = 0; stall = 0; flush = 0; size = 0; a = 0; b = 0; result = 0;
    carry_out = 0; is_sub = 0; upd_mask = 0; df_val = 0; load_en = 0; load_val = 0;
  endtask

  task automatic op(input logic [1:0] s, input logic [31:0] ia, input logic [31:0] ib,
                    input logic [31:0] r, input logic co, input logic sub, input logic [6:0] m);
    idle();
    v_in = 1; size = s; a = ia; b = ib; result = r; carry_out = co; is_sub = sub; upd_mask = m;
  endtask

  // Inputs are set just after a negedge; check forwarding, queue the expected commit, advance.
  task automatic step(input string name, input logic [31:0] fwd, input bit push);
    #1;
    chk(name, flags_fwd, fwd);
    if (push) sb_q.push_back(fwd);
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1; v_in = 1; a = $urandom; b = $urandom; result = $urandom; upd_mask = 7'h7F;
    load_en = 1; load_val = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    repeat (2) begin
      chk("rst_flags", flags, 0); chk("rst_vout", {31'b0, v_out}, 0); chk("rst_fwd", flags_fwd, 0);
      @(negedge clk);
    end
    reset = 0; idle();
    #1; chk("post_rst_fwd", flags_fwd, 0);
    @(negedge clk);
    chk("post_rst_flags", flags, 0); chk("post_rst_vout", {31'b0, v_out}, 0);

    op(2'b00, 32'h7F, 32'h01, 32'h80, 0, 0, 7'b1011111); step("add8_of", 32'h0890, 1);
    op(2'b10, 32'h12345678, 32'h12345678, 0, 1, 1, 7'b1011111); step("cmp32_eq", 32'h0044, 1);
    idle(); v_in = 1; load_en = 1; load_val = 32'h1; step("load_cf", 32'h0001, 1);
    idle(); v_in = 1; upd_mask = 7'b0100000; df_val = 1; step("std", 32'h0401, 1);
    op(2'b10, 32'hFFFF_FFFF, 32'h1, 0, 1, 0, 7'b1011110); step("inc_keep_cf", 32'h0455, 1);
    idle(); v_in = 1; load_en = 1; load_val = 32'hFFFF_FFFF; step("popf", 32'h0CD5, 1);

    idle(); v_in = 1; stall = 1; flush = 1; upd_mask = 7'h7F; result = 32'h55;
    repeat (3) step("stall_flush_fwd", 32'h0CD5, 0);
    chk("stall_flags", flags, 32'h0CD5); chk("stall_vout", {31'b0, v_out}, 1);
    stall = 0; step("flush_fwd", 32'h0CD5, 0);
    chk("flush_vout", {31'b0, v_out}, 0); chk("flush_flags", flags, 32'h0CD5);

    op(2'b00, 32'h05, 32'h05, 0, 0, 1, 7'b1011111); step("b2b_a", 32'h0445, 1);
    op(2'b01, 32'h1, 32'h1, 32'h2, 0, 0, 7'b1011111);
    chk("b2b_lag", flags, 32'h0445); chk("b2b_vout1", {31'b0, v_out}, 1);
    step("b2b_b", 32'h0400, 1);
    idle();
    chk("b2b_vout2", {31'b0, v_out}, 1); chk("b2b_flags", flags, 32'h0400);
    step("idle_fwd", 32'h0400, 0);
    chk("idle_vout", {31'b0, v_out}, 0);

    op(2'b00, 32'h0, 32'h0, 32'hFFFF_FF00, 0, 0, 7'b0001000); step("zf_size8_hi_ignored", 32'h0440, 1);
    op(2'b11, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 7'b1000000); step("of_size_reserved", 32'h0C40, 1);
    op(2'b01, 32'hFFFF_7FFF, 32'h0000_0001, 32'h0000_8000, 0, 0, 7'b1010000); step("of16", 32'h0CC0, 1);
    op(2'b10, 32'h1, 32'h1, 32'h1, 1, 0, 7'b0000000); step("mask0", 32'h0CC0, 1);
    idle(); step("idle2", 32'h0CC0, 0);
    chk("mask0_vout_drop", {31'b0, v_out}, 0);

    op(2'b10, 32'h1, 32'h1, 32'h1, 1, 0, 7'h7F); stall = 1; reset = 1;
    @(negedge clk);
    chk("rst_in_stall_flags", flags, 0); chk("rst_in_stall_vout", {31'b0, v_out}, 0);
    reset = 0; idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
